// File: rtl/filter_event_ctrl.sv
// ============================================================================
// Module  : filter_event_ctrl
// Purpose : Threshold event detector. Captures peak amplitude, timestamp and
//           pile-up flag of shaped samples, then queues them in a FWFT FIFO.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module filter_event_ctrl #(
    parameter int SIZE_OUT  = 17,
    parameter int TS_W      = 16,
    parameter int FLUSH_CYC = 24,
    parameter int DEAD_CYC  = 8,
    parameter int MAX_W     = 255,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [SIZE_OUT-1:0] threshold,
    input  logic signed [SIZE_OUT-1:0] filt_data,
    output logic                       filt_rst_n,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic signed [SIZE_OUT-1:0] ev_amp,
    output logic [TS_W-1:0]            ev_time,
    output logic                       ev_pileup,
    output logic                       busy,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam int c_FC_W  = $clog2(FLUSH_CYC + 1);
    localparam int c_WC_W  = $clog2(MAX_W + 1);
    localparam int c_DC_W  = $clog2(DEAD_CYC + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_EW    = SIZE_OUT + TS_W + 1;

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_IDLE  = 2'd1,
        S_RISE  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [TS_W-1:0]            r_timer;
    logic [c_FC_W-1:0]          r_fcnt;
    logic [c_WC_W-1:0]          r_wcnt;
    logic [c_DC_W-1:0]          r_dcnt;
    logic signed [SIZE_OUT-1:0] r_peak;
    logic [TS_W-1:0]            r_ts;
    logic                       r_pileup;

    logic w_above;
    logic w_start;
    logic w_peak_upd;
    logic w_pile_set;
    logic w_push;

    assign w_above = filt_data > threshold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_peak_upd  = 1'b0;
        w_pile_set  = 1'b0;
        w_push      = 1'b0;
        if (!enable) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_FLUSH: begin
                    if (r_fcnt == c_FC_W'(FLUSH_CYC - 1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_above) begin
                        w_state_nxt = S_RISE;
                        w_start     = 1'b1;
                    end
                end
                S_RISE: begin
                    if (!w_above) begin
                        w_state_nxt = S_DEAD;
                    end else begin
                        w_peak_upd = filt_data > r_peak;
                        // Pulse too wide: treat as pile-up and stop tracking.
                        if (r_wcnt == c_WC_W'(MAX_W - 1)) begin
                            w_pile_set  = 1'b1;
                            w_state_nxt = S_DEAD;
                        end
                    end
                end
                default: begin
                    w_pile_set = w_above;
                    if (r_dcnt == c_DC_W'(DEAD_CYC - 1)) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer  <= '0;
            r_fcnt   <= '0;
            r_wcnt   <= '0;
            r_dcnt   <= '0;
            r_peak   <= '0;
            r_ts     <= '0;
            r_pileup <= 1'b0;
        end else begin
            r_timer <= r_timer + TS_W'(1);
            // Each counter runs only while its state is active, else holds zero.
            r_fcnt  <= (enable && r_state == S_FLUSH) ? r_fcnt + c_FC_W'(1) : '0;
            r_wcnt  <= (enable && r_state == S_RISE)  ? r_wcnt + c_WC_W'(1) : '0;
            r_dcnt  <= (enable && r_state == S_DEAD)  ? r_dcnt + c_DC_W'(1) : '0;
            if (w_start || w_peak_upd) begin
                r_peak <= filt_data;
            end
            if (w_start) begin
                r_ts <= r_timer;
            end
            if (w_start) begin
                r_pileup <= 1'b0;
            end else if (w_pile_set) begin
                r_pileup <= 1'b1;
            end
        end
    end

    logic [c_EW-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_EW-1:0]    w_head;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;

    assign w_pop  = ev_valid && ev_ready;
    assign w_full = r_count == c_CNT_W'(DEPTH);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // The final dead-time sample may itself raise pile-up, so fold it in here.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {r_peak, r_ts, r_pileup | w_above};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= (r_wptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rptr + c_PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign ev_valid   = r_count != '0;
    assign ev_amp     = w_head[c_EW-1 -: SIZE_OUT];
    assign ev_time    = w_head[TS_W:1];
    assign ev_pileup  = w_head[0];
    assign filt_rst_n = r_state != S_FLUSH;
    assign busy       = r_state != S_IDLE;

endmodule

`default_nettype wire

// File: tb/tb_filter_event_ctrl.sv
// ============================================================================
// Module  : tb_filter_event_ctrl
// Purpose : Directed + random bench for filter_event_ctrl against a queue model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_filter_event_ctrl;

    localparam int SIZE_OUT  = 17;
    localparam int TS_W      = 16;
    localparam int FLUSH_CYC = 24;
    localparam int DEAD_CYC  = 8;
    localparam int MAX_W     = 255;
    localparam int DEPTH     = 4;

    localparam int M_FLUSH = 0;
    localparam int M_IDLE  = 1;
    localparam int M_RISE  = 2;
    localparam int M_DEAD  = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       enable;
    logic signed [SIZE_OUT-1:0] threshold;
    logic signed [SIZE_OUT-1:0] filt_data;
    logic                       filt_rst_n;
    logic                       ev_valid;
    logic                       ev_ready;
    logic signed [SIZE_OUT-1:0] ev_amp;
    logic [TS_W-1:0]            ev_time;
    logic                       ev_pileup;
    logic                       busy;
    logic                       overflow;
    logic                       clear_ovf;

    filter_event_ctrl #(
        .SIZE_OUT (SIZE_OUT),
        .TS_W     (TS_W),
        .FLUSH_CYC(FLUSH_CYC),
        .DEAD_CYC (DEAD_CYC),
        .MAX_W    (MAX_W),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .threshold (threshold),
        .filt_data (filt_data),
        .filt_rst_n(filt_rst_n),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_amp    (ev_amp),
        .ev_time   (ev_time),
        .ev_pileup (ev_pileup),
        .busy      (busy),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amp;
        int tim;
        bit pile;
    } ev_t;

    // Reference model: spec-level state, cycle counter and an event queue.
    int  m_mode  = M_FLUSH;
    int  m_cnt   = 0;
    int  m_timer = 0;
    int  m_peak  = 0;
    int  m_ts    = 0;
    bit  m_pile  = 1'b0;
    bit  m_ovf   = 1'b0;
    ev_t m_q[$];
    bit  m_live  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    bit s_rst_n, s_busy, s_valid, s_ovf, s_pile;
    int s_amp, s_time;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  fd;
        int  thr;
        bit  pop;
        bit  push;
        bit  drop;
        ev_t e;
        fd  = int'(filt_data);
        thr = int'(threshold);
        if (reset) begin
            m_mode = M_FLUSH; m_cnt = 0; m_timer = 0; m_peak = 0;
            m_ts = 0; m_pile = 1'b0; m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        pop  = (m_q.size() != 0) && ev_ready;
        push = 1'b0;
        if (!enable) begin
            m_mode = M_FLUSH;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                M_FLUSH: begin
                    m_cnt++;
                    if (m_cnt == FLUSH_CYC) begin m_mode = M_IDLE; m_cnt = 0; end
                end
                M_IDLE: begin
                    if (fd > thr) begin
                        m_mode = M_RISE; m_peak = fd; m_ts = m_timer;
                        m_pile = 1'b0; m_cnt = 0;
                    end
                end
                M_RISE: begin
                    m_cnt++;
                    if (fd <= thr) begin
                        m_mode = M_DEAD; m_cnt = 0;
                    end else begin
                        if (fd > m_peak) m_peak = fd;
                        if (m_cnt == MAX_W) begin
                            m_pile = 1'b1; m_mode = M_DEAD; m_cnt = 0;
                        end
                    end
                end
                default: begin
                    if (fd > thr) m_pile = 1'b1;
                    m_cnt++;
                    if (m_cnt == DEAD_CYC) begin push = 1'b1; m_mode = M_IDLE; m_cnt = 0; end
                end
            endcase
        end
        if (pop) void'(m_q.pop_front());
        drop = 1'b0;
        if (push) begin
            if (m_q.size() < DEPTH) begin
                e.amp = m_peak; e.tim = m_ts; e.pile = m_pile;
                m_q.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clear_ovf) m_ovf = 1'b0;
        m_timer = (m_timer + 1) % (1 << TS_W);
    endtask

    // One clock: sample/compare at negedge, advance model at posedge.
    task automatic cycle();
        @(negedge clk);
        s_rst_n = filt_rst_n; s_busy = busy; s_valid = ev_valid; s_ovf = overflow;
        s_amp = int'(ev_amp); s_time = int'(ev_time); s_pile = ev_pileup;
        if (m_live) begin
            check("filt_rst_n", filt_rst_n, longint'(m_mode != M_FLUSH));
            check("busy", busy, longint'(m_mode != M_IDLE));
            check("ev_valid", ev_valid, longint'(m_q.size() != 0));
            check("overflow", overflow, longint'(m_ovf));
            if (m_q.size() != 0) begin
                check("ev_amp", longint'(ev_amp), longint'(m_q[0].amp));
                check("ev_time", longint'(ev_time), longint'(m_q[0].tim));
                check("ev_pileup", ev_pileup, longint'(m_q[0].pile));
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic gen_event(input int amp, input int mid, input int pile_at, input bit rdy_on_push);
        filt_data = 150; cycle();
        filt_data = amp; cycle();
        filt_data = mid; cycle();
        filt_data = 90;  cycle();
        for (int i = 1; i <= DEAD_CYC; i++) begin
            filt_data = (i == pile_at) ? 120 : 0;
            ev_ready  = rdy_on_push && (i == DEAD_CYC);
            cycle();
        end
        filt_data = 0;
        ev_ready  = 1'b0;
    endtask

    initial begin
        int n_low;
        int guard;
        int exp_amp[4];
        reset = 1'b1; enable = 1'b1; threshold = 100; filt_data = 0;
        ev_ready = 1'b0; clear_ovf = 1'b0;
        cycle();
        m_live = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_rst_n", s_rst_n, 0);
        check("rst_busy", s_busy, 1);
        check("rst_valid", s_valid, 0);
        check("rst_ovf", s_ovf, 0);

        // Flush length with enable held high.
        n_low = 0; guard = 0;
        do begin
            cycle();
            if (!s_rst_n) n_low++;
            guard++;
        end while (!s_rst_n && guard < 100);
        check("flush_len", n_low, FLUSH_CYC);
        check("idle_busy", s_busy, 0);

        guard = 0;
        while (m_timer != 40 && guard < 1000) begin cycle(); guard++; end
        check("timer_reach", m_timer, 40);

        // Basic event: 150,300,250,90 then zeros.
        gen_event(300, 250, 0, 1'b0);
        check("lat_early", s_valid, 0);
        cycle();
        check("ev1_valid", s_valid, 1);
        check("ev1_amp", s_amp, 300);
        check("ev1_time", s_time, 40);
        check("ev1_pile", s_pile, 0);
        ev_ready = 1'b1; cycle(); ev_ready = 1'b0;

        // Re-trigger on the third dead cycle.
        gen_event(300, 250, 3, 1'b0);
        cycle();
        check("ev2_amp", s_amp, 300);
        check("ev2_pile", s_pile, 1);
        ev_ready = 1'b1; cycle(); ev_ready = 1'b0;

        // Five events with no consumer: fifth is dropped.
        for (int k = 0; k < 5; k++) gen_event(200 + 10 * k, 110, 0, 1'b0);
        cycle();
        check("ovf_set", s_ovf, 1);
        check("ovf_head", s_amp, 200);
        clear_ovf = 1'b1; cycle(); clear_ovf = 1'b0;
        cycle();
        check("ovf_clr", s_ovf, 0);

        // Full FIFO: push and pop on the same edge.
        gen_event(250, 110, 0, 1'b1);
        cycle();
        check("fp_valid", s_valid, 1);
        check("fp_head", s_amp, 210);
        check("fp_ovf", s_ovf, 0);
        exp_amp = '{210, 220, 230, 250};
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("drain_amp", s_amp, exp_amp[k]);
        end
        ev_ready = 1'b0;
        cycle();
        check("drain_empty", s_valid, 0);

        // Pulse wider than MAX_W.
        filt_data = 200;
        for (int i = 0; i < MAX_W + 5; i++) cycle();
        filt_data = 0;
        for (int i = 0; i < DEAD_CYC + 2; i++) cycle();
        check("wide_pile", s_pile, 1);
        check("wide_amp", s_amp, 200);
        ev_ready = 1'b1; cycle(); ev_ready = 1'b0;

        // Enable dropped mid-RISE with one event already queued.
        gen_event(260, 110, 0, 1'b0);
        filt_data = 150; cycle();
        filt_data = 300; cycle();
        enable = 1'b0;   cycle();
        enable = 1'b1; filt_data = 0;
        cycle();
        check("abort_rst_n", s_rst_n, 0);
        for (int i = 0; i < FLUSH_CYC + DEAD_CYC + 6; i++) cycle();
        check("abort_valid", s_valid, 1);
        check("abort_amp", s_amp, 260);
        ev_ready = 1'b1; cycle(); ev_ready = 1'b0;
        cycle();
        check("abort_one", s_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) threshold = ($urandom_range(0, 1) == 0) ? 17'sd100 : -17'sd50;
            reset     = ($urandom_range(0, 999) == 0);
            enable    = ($urandom_range(0, 99) != 0);
            ev_ready  = ($urandom_range(0, 3) == 0);
            clear_ovf = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 19))
                0:       filt_data = 17'sh0FFFF;
                1:       filt_data = 17'sh10000;
                default: filt_data = SIZE_OUT'(int'($urandom_range(0, 700)) - 300);
            endcase
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/filter_event_ctrl.md
FILTER_EVENT_CTRL -- requirements
Module: filter_event_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- SIZE_OUT, 17, filter output width, two's complement.
- TS_W, 16, timestamp width.
- FLUSH_CYC, 24, filter reset/settle cycles.
- DEAD_CYC, 8, dead-time cycles after an event.
- MAX_W, 255, maximum cycles allowed in RISE.
- DEPTH, 4, event FIFO depth.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, run enable.
- threshold, in, SIZE_OUT, signed trigger level.
- filt_data, in, SIZE_OUT, signed shaped sample from the filter, one per cycle.
- filt_rst_n, out, 1, active-low reset driven to the shaping filter.
- ev_valid, out, 1, FIFO head valid.
- ev_ready, in, 1, consumer accept.
- ev_amp, out, SIZE_OUT, peak amplitude of the head event.
- ev_time, out, TS_W, timestamp of the head event.
- ev_pileup, out, 1, pile-up flag of the head event.
- busy, out, 1, high whenever state is not IDLE.
- overflow, out, 1, sticky event-drop flag.
- clear_ovf, in, 1, clears overflow.

Function
REQ-003 The state machine SHALL have states FLUSH, IDLE, RISE and DEAD, all registered.
REQ-004 FLUSH SHALL drive filt_rst_n=0 and count enable-high cycles; after FLUSH_CYC consecutive enable-high cycles it SHALL go to IDLE and drive filt_rst_n=1 from that cycle on.
REQ-005 enable=0 in any state SHALL force FLUSH and restart the flush count; an event in progress SHALL be abandoned without a push, and FIFO contents SHALL be retained.
REQ-006 A free-running TS_W timer SHALL increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-007 IDLE -> RISE SHALL occur when signed filt_data > signed threshold; on that edge peak<=filt_data, ts<=timer, pileup<=0, and the width counter clears.
REQ-008 In RISE, filt_data > peak (signed) SHALL update peak; equal or lower values SHALL hold peak; ts SHALL NOT change.
REQ-009 RISE -> DEAD SHALL occur when filt_data <= threshold, and the dead counter clears.
REQ-010 If RISE lasts MAX_W cycles without falling to threshold, the block SHALL set pileup and go to DEAD.
REQ-011 In DEAD, any cycle with filt_data > threshold SHALL set pileup; peak SHALL NOT update.
REQ-012 After DEAD_CYC cycles in DEAD, the block SHALL push {peak, ts, pileup} to the FIFO and go to IDLE in the same edge.
REQ-013 The FIFO SHALL be first-word-fall-through, DEPTH entries deep; ev_valid=1 iff count>0; ev_amp, ev_time and ev_pileup SHALL present the head entry.
REQ-014 A pop SHALL occur on a cycle with ev_valid && ev_ready; ev_* SHALL be undefined-but-stable when ev_valid=0.
REQ-015 A push into an empty FIFO SHALL make ev_valid=1 in the cycle after the push edge (latency 1).
REQ-016 A push when the FIFO is full and no pop occurs SHALL drop the event and set overflow.
REQ-017 A push and a pop in the same cycle with the FIFO full SHALL both be accepted, with no drop and count unchanged.
REQ-018 A push and a pop in the same cycle with the FIFO empty is not possible because ev_valid=0, so count SHALL become 1.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH.
REQ-020 clear_ovf SHALL clear overflow; a drop in the same cycle as clear_ovf SHALL leave overflow=1.
REQ-021 All amplitude comparisons SHALL be signed SIZE_OUT; no arithmetic widening is required.

Reset
REQ-022 When reset=1 at a clock edge, the block SHALL enter FLUSH and set filt_rst_n=0, ev_valid=0, FIFO count=0, pointers=0, overflow=0, busy=1, timer=0, peak=0, ts=0 and pileup=0.
REQ-023 Reset asserted mid-event or mid-flush SHALL discard all progress; after release, a full FLUSH_CYC flush SHALL be required again.

Verification
REQ-024 The bench SHALL cover: reset, enable=1 held -> filt_rst_n=0 for exactly 24 cycles, then 1; busy falls with the IDLE entry.
REQ-025 The bench SHALL cover: threshold=100, filt_data 0,150,300,250,90,0... with timer=40 at the 150 sample -> one event {amp=300, time=40, pileup=0}, ev_valid high 1 cycle after the 8th DEAD cycle.
REQ-026 The bench SHALL cover: as above but filt_data=120 on the 3rd DEAD cycle -> event pileup=1, amp=300.
REQ-027 The bench SHALL cover: ev_ready=0 with 5 events generated -> first 4 queued in order, 5th dropped, overflow=1; clear_ovf -> overflow=0.
REQ-028 The bench SHALL cover: FIFO full, push and pop in the same cycle -> count stays 4, head advances, no overflow.
REQ-029 The bench SHALL cover: enable dropped during RISE -> no event pushed, filt_rst_n=0 next cycle, existing FIFO entries still readable.
